present_sbox_compress_stage: RTL and testbench

// - Downstream stage of the 3-share, second-order masked PRESENT S-box. Consumes the

---
 rtl/present_sbox_compress_stage_if.sv | 36 +++
 rtl/present_sbox_compress_stage.sv | 114 +++++++++++
 tb/tb_present_sbox_compress_stage.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/present_sbox_compress_stage_if.sv
// present_sbox_compress_stage_if
//   Handshake and data bundle between a masked PRESENT S-box term generator,
//   the compression stage and its consumer.
//   Signals:
//     in_valid / in_ready   : term word handshake (producer -> stage)
//     terms [N_FUNC*9]      : term t of function f at bit f*9+t
//     rnd [N_FUNC*2]        : fresh randomness, two bits per function
//     rnd_valid / rnd_ack   : randomness offer / consumption
//     out_valid / out_ready : output share handshake (stage -> consumer)
//     sh0, sh1, sh2         : output shares, bit f = function f
//   Modports: slave = compression stage view, master = producer/consumer view.
interface present_sbox_compress_stage_if #(
    parameter int N_FUNC = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [N_FUNC*9-1:0]   terms;
    logic [N_FUNC*2-1:0]   rnd;
    logic                  rnd_valid;
    logic                  rnd_ack;
    logic                  out_valid;
    logic                  out_ready;
    logic [N_FUNC-1:0]     sh0;
    logic [N_FUNC-1:0]     sh1;
    logic [N_FUNC-1:0]     sh2;

    modport slave (
        input  in_valid, terms, rnd, rnd_valid, out_ready,
        output in_ready, rnd_ack, out_valid, sh0, sh1, sh2
    );

    modport master (
        output in_valid, terms, rnd, rnd_valid, out_ready,
        input  in_ready, rnd_ack, out_valid, sh0, sh1, sh2
    );
endinterface

// File: rtl/present_sbox_compress_stage.sv
// present_sbox_compress_stage
//   Downstream stage of the 3-share, second-order masked PRESENT S-box.
//   Stage 1 registers the raw component-function terms (glitch barrier).
//   Stage 2 XOR-compresses each function's 9 terms into 3 shares, optionally
//   refreshes them with fresh randomness, and registers the result.
//   Ports:
//     clk      : rising-edge clock
//     rst      : synchronous active-high reset
//     bus      : slave side of present_sbox_compress_stage_if (terms in,
//                randomness in, shares out, all valid/ready handshaked)
//     sbox_cnt : number of S-box outputs delivered, wraps at 16 bits
//   Parameters:
//     N_FUNC   : coordinate functions per S-box
//     REFRESH  : 1 adds randomness refresh in stage 2, 0 ignores rnd
module present_sbox_compress_stage #(
    parameter int N_FUNC  = 4,
    parameter bit REFRESH = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    present_sbox_compress_stage_if.slave bus,
    output logic [15:0]                  sbox_cnt
);
    localparam int TERM_W = N_FUNC * 9;

    logic              s1_valid;
    logic [TERM_W-1:0] s1_terms;
    logic              s1_advance;
    logic              rnd_ok;
    logic              in_ready;
    logic              out_valid;
    logic [N_FUNC-1:0] sh0;
    logic [N_FUNC-1:0] sh1;
    logic [N_FUNC-1:0] sh2;
    logic [N_FUNC-1:0] c0;
    logic [N_FUNC-1:0] c1;
    logic [N_FUNC-1:0] c2;
    logic [N_FUNC-1:0] sh0_next;
    logic [N_FUNC-1:0] sh1_next;
    logic [N_FUNC-1:0] sh2_next;

    // Without refresh, stage 2 never waits on randomness.
    assign rnd_ok     = !REFRESH || bus.rnd_valid;
    assign s1_advance = s1_valid && (!out_valid || bus.out_ready) && rnd_ok;
    assign in_ready   = !rst && (!s1_valid || s1_advance);

    assign bus.in_ready  = in_ready;
    assign bus.rnd_ack   = REFRESH && !rst && s1_advance;
    assign bus.out_valid = out_valid;
    assign bus.sh0       = sh0;
    assign bus.sh1       = sh1;
    assign bus.sh2       = sh2;

    // Compression works only on registered terms; each share's tree sees
    // just its own three terms plus randomness, never another share index.
    always_comb begin
        c0       = '0;
        c1       = '0;
        c2       = '0;
        sh0_next = '0;
        sh1_next = '0;
        sh2_next = '0;
        for (int unsigned f = 0; f < N_FUNC; f++) begin
            c0[f] = s1_terms[f*9+0] ^ s1_terms[f*9+1] ^ s1_terms[f*9+2];
            c1[f] = s1_terms[f*9+3] ^ s1_terms[f*9+4] ^ s1_terms[f*9+5];
            c2[f] = s1_terms[f*9+6] ^ s1_terms[f*9+7] ^ s1_terms[f*9+8];
            if (REFRESH) begin
                // r0 and r1 each appear in exactly two shares, so the
                // unmasked value sh0^sh1^sh2 is unchanged.
                sh0_next[f] = c0[f] ^ bus.rnd[2*f];
                sh1_next[f] = c1[f] ^ bus.rnd[2*f+1];
                sh2_next[f] = c2[f] ^ bus.rnd[2*f] ^ bus.rnd[2*f+1];
            end else begin
                sh0_next[f] = c0[f];
                sh1_next[f] = c1[f];
                sh2_next[f] = c2[f];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_terms  <= '0;
            out_valid <= 1'b0;
            sh0       <= '0;
            sh1       <= '0;
            sh2       <= '0;
            sbox_cnt  <= '0;
        end else begin
            if (bus.in_valid && in_ready) begin
                s1_valid <= 1'b1;
                s1_terms <= bus.terms;
            end else if (s1_advance) begin
                s1_valid <= 1'b0;
            end

            // A load in the same cycle as a handshake replaces the data
            // and keeps out_valid asserted.
            if (s1_advance) begin
                out_valid <= 1'b1;
                sh0       <= sh0_next;
                sh1       <= sh1_next;
                sh2       <= sh2_next;
            end else if (bus.out_ready) begin
                out_valid <= 1'b0;
            end

            if (out_valid && bus.out_ready) begin
                sbox_cnt <= sbox_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_present_sbox_compress_stage.sv
// tb_present_sbox_compress_stage
//   Scoreboard bench for present_sbox_compress_stage. Two instances: dut_r
//   with refresh, dut_p without. Expected compressed triples are queued at
//   input handshakes, consumed randomness is queued at rnd_ack, and monitors
//   compare shares and counters on every output handshake.
module tb_present_sbox_compress_stage;
    localparam int NF = 4;
    localparam int TW = NF * 9;
    localparam int RW = NF * 2;

    typedef logic [2:0][NF-1:0] grp_t;

    logic clk = 1'b0;
    logic rst;
    logic [15:0] cnt_r;
    logic [15:0] cnt_p;

    always #5 clk = ~clk;

    present_sbox_compress_stage_if #(.N_FUNC(NF)) bus_r ();
    present_sbox_compress_stage_if #(.N_FUNC(NF)) bus_p ();

    present_sbox_compress_stage #(.N_FUNC(NF), .REFRESH(1'b1)) dut_r (
        .clk(clk), .rst(rst), .bus(bus_r), .sbox_cnt(cnt_r)
    );
    present_sbox_compress_stage #(.N_FUNC(NF), .REFRESH(1'b0)) dut_p (
        .clk(clk), .rst(rst), .bus(bus_p), .sbox_cnt(cnt_p)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    bit rnd_rand = 1'b0;
    bit rdy_rand = 1'b0;
    bit rv_rand  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: group k of function f is the XOR of terms 3k..3k+2.
    function automatic grp_t model(input logic [TW-1:0] t);
        grp_t g = '0;
        for (int f = 0; f < NF; f++)
            for (int k = 0; k < 9; k++)
                g[k/3][f] = g[k/3][f] ^ t[f*9+k];
        return g;
    endfunction

    function automatic grp_t refresh(input grp_t g, input logic [RW-1:0] r);
        grp_t s;
        for (int f = 0; f < NF; f++) begin
            s[0][f] = g[0][f] ^ r[2*f];
            s[1][f] = g[1][f] ^ r[2*f+1];
            s[2][f] = g[2][f] ^ r[2*f] ^ r[2*f+1];
        end
        return s;
    endfunction

    // ---------------- monitor / scoreboard, refreshing instance ----------
    grp_t            exp_q_r[$];
    logic [RW-1:0]   rnd_q_r[$];
    logic [15:0]     cnt_m_r;
    logic            hold_r;
    logic [3*NF-1:0] held_r;

    always @(negedge clk) begin
        if (rst) begin
            exp_q_r.delete();
            rnd_q_r.delete();
            cnt_m_r = '0;
            hold_r  = 1'b0;
        end else begin
            if (bus_r.in_valid && bus_r.in_ready)
                exp_q_r.push_back(model(bus_r.terms));
            if (bus_r.rnd_ack) begin
                check("r_ack_needs_rnd_valid", bus_r.rnd_valid, 1);
                rnd_q_r.push_back(bus_r.rnd);
            end
            if (hold_r) begin
                check("r_hold_out_valid", bus_r.out_valid, 1);
                if (bus_r.out_valid)
                    check("r_hold_shares", {bus_r.sh0, bus_r.sh1, bus_r.sh2}, held_r);
            end
            if (bus_r.out_valid && bus_r.out_ready) begin
                check("r_sbox_cnt", cnt_r, cnt_m_r);
                cnt_m_r = cnt_m_r + 16'd1;
                check("r_output_pending", (exp_q_r.size() != 0 && rnd_q_r.size() != 0), 1);
                if (exp_q_r.size() != 0 && rnd_q_r.size() != 0) begin
                    grp_t g;
                    grp_t s;
                    g = exp_q_r.pop_front();
                    s = refresh(g, rnd_q_r.pop_front());
                    check("r_sh0", bus_r.sh0, s[0]);
                    check("r_sh1", bus_r.sh1, s[1]);
                    check("r_sh2", bus_r.sh2, s[2]);
                    check("r_unmasked", bus_r.sh0 ^ bus_r.sh1 ^ bus_r.sh2, g[0] ^ g[1] ^ g[2]);
                end
            end
            hold_r = bus_r.out_valid && !bus_r.out_ready;
            held_r = {bus_r.sh0, bus_r.sh1, bus_r.sh2};
        end
    end

    // ---------------- monitor / scoreboard, plain instance ---------------
    grp_t        exp_q_p[$];
    logic [15:0] cnt_m_p;

    always @(negedge clk) begin
        if (rst) begin
            exp_q_p.delete();
            cnt_m_p = '0;
        end else begin
            if (bus_p.in_valid && bus_p.in_ready)
                exp_q_p.push_back(model(bus_p.terms));
            check("p_rnd_ack_low", bus_p.rnd_ack, 0);
            if (bus_p.out_valid && bus_p.out_ready) begin
                check("p_sbox_cnt", cnt_p, cnt_m_p);
                cnt_m_p = cnt_m_p + 16'd1;
                check("p_output_pending", exp_q_p.size() != 0, 1);
                if (exp_q_p.size() != 0) begin
                    grp_t g;
                    g = exp_q_p.pop_front();
                    check("p_sh0", bus_p.sh0, g[0]);
                    check("p_sh1", bus_p.sh1, g[1]);
                    check("p_sh2", bus_p.sh2, g[2]);
                end
            end
        end
    end

    // ---------------- stimulus helpers -----------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rand) begin
            bus_r.rnd = RW'($urandom);
            bus_p.rnd = RW'($urandom);
        end
        if (rdy_rand) bus_r.out_ready = ($urandom_range(0, 3) != 0);
        if (rv_rand)  bus_r.rnd_valid = ($urandom_range(0, 3) != 0);
    endtask

    function automatic logic [TW-1:0] rand_terms();
        return TW'({$urandom, $urandom});
    endfunction

    task automatic wait_accept_r(input int limit);
        bit acc = 1'b0;
        for (int i = 0; i < limit && !acc; i++) begin
            @(negedge clk);
            acc = bus_r.in_ready;
            tick();
        end
        check("r_accept_in_time", acc, 1);
        bus_r.in_valid = 1'b0;
    endtask

    task automatic send_one_r(input logic [TW-1:0] t);
        bus_r.in_valid = 1'b1;
        bus_r.terms    = t;
        wait_accept_r(50);
    endtask

    task automatic send_one_p(input logic [TW-1:0] t);
        bit acc = 1'b0;
        bus_p.in_valid = 1'b1;
        bus_p.terms    = t;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = bus_p.in_ready;
            tick();
        end
        check("p_accept_in_time", acc, 1);
        bus_p.in_valid = 1'b0;
    endtask

    task automatic stream_r(input int n, input bit full);
        int sent  = 0;
        int guard = 0;
        bit acc;
        bus_r.in_valid = 1'b0;
        while (sent < n && guard < n * 4 + 100) begin
            guard++;
            if (!bus_r.in_valid && (full || $urandom_range(0, 3) != 0)) begin
                bus_r.in_valid = 1'b1;
                bus_r.terms    = rand_terms();
            end
            @(negedge clk);
            acc = bus_r.in_valid && bus_r.in_ready;
            tick();
            if (acc) begin
                sent++;
                bus_r.in_valid = 1'b0;
            end
        end
        bus_r.in_valid = 1'b0;
        check("r_stream_sent", sent, n);
    endtask

    task automatic drain_r(input int limit);
        bus_r.out_ready = 1'b1;
        bus_r.rnd_valid = 1'b1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            #1;
            if (exp_q_r.size() == 0) break;
        end
        check("r_drain_empty", exp_q_r.size(), 0);
        check("r_rnd_queue_empty", rnd_q_r.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    logic [15:0] wrap_exp [3];

    initial begin
        wrap_exp = '{16'hFFFF, 16'h0000, 16'h0001};
        rst = 1'b1;
        bus_r.in_valid = 1'b0; bus_r.terms = '0; bus_r.rnd = '0;
        bus_r.rnd_valid = 1'b0; bus_r.out_ready = 1'b1;
        bus_p.in_valid = 1'b0; bus_p.terms = '0; bus_p.rnd = '0;
        bus_p.rnd_valid = 1'b0; bus_p.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        bus_r.in_valid  = 1'b1;
        bus_r.rnd_valid = 1'b1;
        bus_p.in_valid  = 1'b1;
        @(negedge clk);
        check("rst_in_ready_r", bus_r.in_ready, 0);
        check("rst_rnd_ack_r", bus_r.rnd_ack, 0);
        check("rst_in_ready_p", bus_p.in_ready, 0);
        check("rst_out_valid_r", bus_r.out_valid, 0);
        check("rst_shares_r", {bus_r.sh0, bus_r.sh1, bus_r.sh2}, 0);
        check("rst_cnt_r", cnt_r, 0);
        check("rst_out_valid_p", bus_p.out_valid, 0);
        check("rst_cnt_p", cnt_p, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus_r.in_valid  = 1'b0;
        bus_p.in_valid  = 1'b0;
        bus_r.rnd_valid = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready_r", bus_r.in_ready, 1);
        check("post_rst_in_ready_p", bus_p.in_ready, 1);
        @(posedge clk);
        #1;
        rnd_rand = 1'b1;

        // Plain compression, f0 terms 0..2 set: sh0[0]=1 after two stages
        send_one_p(TW'(9'b000_000_111));
        @(negedge clk);
        check("p_lat_stage1", bus_p.out_valid, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("p_lat_out_valid", bus_p.out_valid, 1);
        check("p_dir_sh0", bus_p.sh0, 4'b0001);
        check("p_dir_sh1", bus_p.sh1, 4'b0000);
        check("p_dir_sh2", bus_p.sh2, 4'b0000);
        @(posedge clk);
        #1;

        // Plain instance, back-to-back stream with rnd_valid low
        for (int i = 0; i < 20; i++) begin
            bus_p.in_valid = 1'b1;
            bus_p.terms    = rand_terms();
            @(negedge clk);
            check("p_full_rate_ready", bus_p.in_ready, 1);
            tick();
        end
        bus_p.in_valid = 1'b0;
        repeat (4) tick();
        check("p_drain_empty", exp_q_p.size(), 0);

        // Refresh, all-ones terms, rnd pairs 2'b01: r0=1, r1=0
        rnd_rand = 1'b0;
        bus_r.rnd = 8'h55;
        bus_r.rnd_valid = 1'b1;
        send_one_r('1);
        @(negedge clk);
        check("r_lat_stage1", bus_r.out_valid, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("r_lat_out_valid", bus_r.out_valid, 1);
        check("r_dir_sh0", bus_r.sh0, 4'h0);
        check("r_dir_sh1", bus_r.sh1, 4'hF);
        check("r_dir_sh2", bus_r.sh2, 4'h0);
        check("r_dir_unmasked", bus_r.sh0 ^ bus_r.sh1 ^ bus_r.sh2, 4'hF);
        @(posedge clk);
        #1;
        drain_r(20);
        rnd_rand = 1'b1;

        // Randomness stall with two inputs queued
        bus_r.rnd_valid = 1'b0;
        bus_r.in_valid  = 1'b1;
        bus_r.terms     = rand_terms();
        @(negedge clk);
        check("stall_first_accept", bus_r.in_ready, 1);
        tick();
        bus_r.terms = rand_terms();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", bus_r.in_ready, 0);
            check("stall_rnd_ack", bus_r.rnd_ack, 0);
            check("stall_out_valid", bus_r.out_valid, 0);
            tick();
        end
        bus_r.rnd_valid = 1'b1;
        wait_accept_r(20);
        drain_r(20);

        // Output back-pressure for 3 cycles
        bus_r.out_ready = 1'b0;
        bus_r.in_valid  = 1'b1;
        bus_r.terms     = rand_terms();
        @(negedge clk);
        tick();
        bus_r.terms = rand_terms();
        @(negedge clk);
        check("bp_second_accept", bus_r.in_ready, 1);
        tick();
        bus_r.terms = rand_terms();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", bus_r.in_ready, 0);
            check("bp_out_valid", bus_r.out_valid, 1);
            tick();
        end
        bus_r.out_ready = 1'b1;
        wait_accept_r(20);
        drain_r(20);

        // Reset with both stages full
        bus_r.out_ready = 1'b0;
        bus_r.in_valid  = 1'b1;
        bus_r.terms     = rand_terms();
        @(negedge clk);
        tick();
        bus_r.terms = rand_terms();
        @(negedge clk);
        tick();
        bus_r.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", bus_r.in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", bus_r.out_valid, 0);
        check("midrst_cnt", cnt_r, 0);
        check("midrst_in_ready_after", bus_r.in_ready, 1);
        @(posedge clk);
        #1;
        bus_r.out_ready = 1'b1;
        send_one_r(rand_terms());
        @(negedge clk);
        check("midrst_lat_stage1", bus_r.out_valid, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midrst_lat_out_valid", bus_r.out_valid, 1);
        @(posedge clk);
        #1;
        drain_r(20);

        // Random traffic: random idles, out_ready and rnd_valid
        rdy_rand = 1'b1;
        rv_rand  = 1'b1;
        stream_r(300, 1'b0);
        rdy_rand = 1'b0;
        rv_rand  = 1'b0;
        drain_r(60);

        // Counter wrap: 0xFFFE deliveries, then three more
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_r.out_ready = 1'b1;
        bus_r.rnd_valid = 1'b1;
        stream_r(65534, 1'b1);
        drain_r(20);
        @(negedge clk);
        check("wrap_preload", cnt_r, 16'hFFFE);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            send_one_r(rand_terms());
            drain_r(20);
            @(negedge clk);
            check("wrap_cnt", cnt_r, wrap_exp[k]);
            @(posedge clk);
            #1;
        end

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
